time_set_fsm: RTL and testbench
===============================

Name: time_set_fsm

Overview:
- Parametrised successor to the clock's time-setting logic.
- Captures the running time when the mode selector enters set mode, then lets the user edit each field with three buttons.
- Buttons: mid selects the next field, r increments, l decrements. Arithmetic is BCD and calendar-correct.
- On final confirmation it presents the edited time with a one-cycle load pulse, which the running-time counter uses to reload.

Parameters:
- SET_MODE, 4'd0: value of mode that activates editing.
- YEAR_RESET, 16'h2023: BCD reset value of year.
- YEAR_MIN, 16'h2000: lowest editable year (BCD).
- YEAR_MAX, 16'h2099: highest editable year (BCD).
- REPEAT_DELAY, 24'd5_000_000: hold cycles before auto-repeat starts (macro only).
- REPEAT_PERIOD, 24'd1_000_000: cycles between repeats (macro only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  4  display/function mode selector
- button_mid  in  1  debounced, synchronised level
- button_l  in  1  debounced level; decrement
- button_r  in  1  debounced level; increment
- cur_year  in  16  running time, BCD; sampled on entry
- cur_month, cur_day, cur_hour, cur_minute, cur_sec  in  8 each  running time, BCD
- year  out  16  edited year, BCD
- month, day, hour, minute, sec  out  8 each  edited fields, BCD
- field_sel  out  3  field being edited: 0 none, 1 year … 6 sec (for display blink)
- set_active  out  1  high while editing
- load  out  1  one-cycle pulse; outputs are valid to load

Behaviour:
- Reset is asynchronous, active-low; clk is the only clock.
- Reset values: year=YEAR_RESET, month=8'h01, day=8'h01, hour/minute/sec=0, field_sel=0, set_active=0, load=0, state=IDLE.
- Button edges: each button goes through an internal registered rising-edge detect, so one press produces one action. Buttons are otherwise ignored in IDLE and DONE.
- States: IDLE, E_YEAR, E_MONTH, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT, DONE.
- IDLE -> E_YEAR on the first cycle with mode==SET_MODE.
  - Same edge: copy all cur_* into the outputs.
  - set_active=1, field_sel=1 from the next cycle.
- Mid edge advances E_YEAR -> E_MONTH -> … -> E_SEC -> COMMIT.
- COMMIT lasts one cycle: load=1, then DONE.
- DONE: set_active=0, field_sel=0. Leaves to IDLE when mode!=SET_MODE.
- Leaving set mode mid-edit:
  - Any E_* state with mode!=SET_MODE -> IDLE; no load pulse.
  - Outputs keep their edited values.
- Event priority within one cycle: mode exit > mid > (r xor l). If r and l edges coincide: no change.
- Edits take effect the cycle after the edge. Each edit steps exactly one BCD count, with wrap-around:
  - year: YEAR_MIN..YEAR_MAX
  - month: 01..12
  - day: 01..DIM
  - hour: 00..23
  - minute, sec: 00..59
  - Increment at max -> min; decrement at min -> max.
- DIM is 31/30/28 by month; February is 29 when leap.
  - leap = (yy%4==0 && yy!=00) || (yy==00 && cc%4==0), where cc/yy are the high/low BCD byte pairs of year.
- Day clamp: when a month or year edit makes day > DIM, day is set to DIM in the same cycle.
- Out-of-range cur_* values at capture are copied as-is. The first edit of such a field maps it to min (increment) or max (decrement).
- BCD digits never hold A–F after any edit.

Optional Feature:
- Macro: TIME_SET_AUTOREPEAT_EN.
- Defined:
  - Holding r or l for REPEAT_DELAY cycles generates one extra step, then one more every REPEAT_PERIOD cycles until release.
  - The counter clears on release, on a field change, or when both r and l are held.
- Undefined: one step per press only; the repeat counters and both repeat parameters are unused.

Decomposition:
- Package time_set_pkg holds:
  - field index localparams (F_NONE..F_SEC)
  - state encoding
  - BCD limit constants
  - function days_in_month(month, year) with the leap rule
- Sub-module bcd_step: 8-bit two-digit BCD inc/dec with min/max wrap, used for month/day/hour/minute/sec.
- year uses two chained instances: a low-pair carry/borrow steps the high pair, with a YEAR_MIN/YEAR_MAX override.

Test Plan:
- Capture and commit:
  - Stimulus: reset; cur=2024-02-29 23:59:59; mode 5 -> 0; then six mid presses.
  - Required: outputs=captured values; field_sel 1..6; load high exactly one cycle; set_active drops.
- Day clamp:
  - Stimulus: E_MONTH with month=01, day=31; one r press.
  - Required: month=02, day=29 if year=2024, day=28 if year=2023.
- Wraps:
  - Stimulus: minute=59, r -> 00; hour=00, l -> 23; year=16'h2099, r -> 16'h2000; month=12, r -> 01.
- Abort:
  - Stimulus: mode changes to 2 while in E_HOUR.
  - Required: state IDLE; no load pulse; edited hour retained.
- Simultaneous events:
  - Stimulus: r and l rise on the same cycle.
  - Required: no change.
  - Stimulus: mid and r on the same cycle.
  - Required: field advances, value unchanged.
  - Stimulus: rst_n low during E_DAY.
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
- Autorepeat (TIME_SET_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4):
  - Stimulus: hold r for 30 cycles at sec=00.
  - Required: sec=06 at release (1 press step + 5 repeat steps).

Source files
------------

// File: rtl/time_set_pkg.sv
// rtl/time_set_pkg.sv - field indices, state encoding, BCD limits and calendar helpers for time_set_fsm
package time_set_pkg;

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_YEAR  = 3'd1;
    localparam logic [2:0] F_MONTH = 3'd2;
    localparam logic [2:0] F_DAY   = 3'd3;
    localparam logic [2:0] F_HOUR  = 3'd4;
    localparam logic [2:0] F_MIN   = 3'd5;
    localparam logic [2:0] F_SEC   = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_E_YEAR,
        S_E_MONTH,
        S_E_DAY,
        S_E_HOUR,
        S_E_MIN,
        S_E_SEC,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [7:0] BCD_ZERO   = 8'h00;
    localparam logic [7:0] PAIR_MAX   = 8'h99;
    localparam logic [7:0] MONTH_MIN  = 8'h01;
    localparam logic [7:0] MONTH_MAX  = 8'h12;
    localparam logic [7:0] DAY_MIN    = 8'h01;
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // A two-digit BCD number is a multiple of 4 when even tens end in 0/4/8 or odd tens end in 2/6.
    function automatic logic bcd_div4(input logic [7:0] b);
        if (!b[4])
            return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
        else
            return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
    endfunction

    function automatic logic is_leap(input logic [15:0] year);
        if (year[7:0] != 8'h00)
            return bcd_div4(year[7:0]);
        else
            return bcd_div4(year[15:8]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [15:0] year);
        logic [7:0] dim;
        case (month)
            8'h02:                      dim = is_leap(year) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
            default:                    dim = 8'h31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/time_set_if.sv
// rtl/time_set_if.sv - mode/button/running-time inputs and edited-time outputs of time_set_fsm
interface time_set_if;
    logic [3:0]  mode;
    logic        button_mid;
    logic        button_l;
    logic        button_r;
    logic [15:0] cur_year;
    logic [7:0]  cur_month;
    logic [7:0]  cur_day;
    logic [7:0]  cur_hour;
    logic [7:0]  cur_minute;
    logic [7:0]  cur_sec;
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  sec;
    logic [2:0]  field_sel;
    logic        set_active;
    logic        load;

    modport master (
        output mode, button_mid, button_l, button_r,
        output cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_sec,
        input  year, month, day, hour, minute, sec,
        input  field_sel, set_active, load
    );

    modport slave (
        input  mode, button_mid, button_l, button_r,
        input  cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_sec,
        output year, month, day, hour, minute, sec,
        output field_sel, set_active, load
    );
endinterface

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - two-digit BCD increment/decrement with lo/hi wrap and out-of-range recovery
module bcd_step
    import time_set_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] lo_lim,
    input  logic [7:0] hi_lim,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result,
    output logic       wrap
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic       in_range;

    assign tens     = value[7:4];
    assign ones     = value[3:0];
    assign in_range = bcd_ok(value) && (value >= lo_lim) && (value <= hi_lim);

    // wrap flags a genuine max->min or min->max roll, never a recovery from garbage.
    always_comb begin
        result = value;
        wrap   = 1'b0;
        if (inc && !dec) begin
            if (!in_range) begin
                result = lo_lim;
            end else if (value == hi_lim) begin
                result = lo_lim;
                wrap   = 1'b1;
            end else if (ones == 4'd9) begin
                result = {tens + 4'd1, 4'd0};
            end else begin
                result = {tens, ones + 4'd1};
            end
        end else if (dec && !inc) begin
            if (!in_range) begin
                result = hi_lim;
            end else if (value == lo_lim) begin
                result = hi_lim;
                wrap   = 1'b1;
            end else if (ones == 4'd0) begin
                result = {tens - 4'd1, 4'd9};
            end else begin
                result = {tens, ones - 4'd1};
            end
        end
    end

endmodule

// File: rtl/time_set_fsm.sv
// rtl/time_set_fsm.sv - time-setting FSM: capture, BCD field edit, commit load pulse; option TIME_SET_AUTOREPEAT_EN
module time_set_fsm
    import time_set_pkg::*;
#(
    parameter logic [3:0]  SET_MODE   = 4'd0,
    parameter logic [15:0] YEAR_RESET = 16'h2023,
    parameter logic [15:0] YEAR_MIN   = 16'h2000,
    parameter logic [15:0] YEAR_MAX   = 16'h2099
`ifdef TIME_SET_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
`endif
) (
    input logic       clk,
    input logic       rst_n,
    time_set_if.slave bus
);

    state_t      state_q, state_d;
    logic        mid_q, l_q, r_q;
    logic        mid_edge, l_edge, r_edge;
    logic        in_set, editing, edit_en;
    logic        step_inc, step_dec;
    logic [15:0] year_q;
    logic [7:0]  month_q, day_q, hour_q, minute_q, sec_q;
    logic [2:0]  field_sel_c;
    logic        set_active_c, load_c;

    logic [7:0]  fld_val, fld_lo, fld_hi, fld_res;
    logic        fld_wrap;
    logic [7:0]  yhi_res;
    logic        yhi_wrap;
    logic [15:0] year_chain, year_next;
    logic        year_ok;
    logic [7:0]  dim_cur, dim_new;

    assign in_set   = (bus.mode == SET_MODE);
    assign editing  = state_q inside {S_E_YEAR, S_E_MONTH, S_E_DAY, S_E_HOUR, S_E_MIN, S_E_SEC};
    assign mid_edge = bus.button_mid & ~mid_q;
    assign l_edge   = bus.button_l & ~l_q;
    assign r_edge   = bus.button_r & ~r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_q <= 1'b0;
            l_q   <= 1'b0;
            r_q   <= 1'b0;
        end else begin
            mid_q <= bus.button_mid;
            l_q   <= bus.button_l;
            r_q   <= bus.button_r;
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    logic [23:0] rep_cnt;
    logic        hold_one, rep_fire;

    assign hold_one = editing && in_set && (bus.button_r ^ bus.button_l);
    assign rep_fire = hold_one && !mid_edge && (rep_cnt == REPEAT_DELAY);

    // After the first repeat the counter is rewound so the next fire lands REPEAT_PERIOD cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rep_cnt <= '0;
        else if (!hold_one || mid_edge)
            rep_cnt <= '0;
        else if (rep_fire)
            rep_cnt <= REPEAT_DELAY - REPEAT_PERIOD + 24'd1;
        else
            rep_cnt <= rep_cnt + 24'd1;
    end

    assign step_inc = (r_edge & ~l_edge) | (rep_fire & bus.button_r);
    assign step_dec = (l_edge & ~r_edge) | (rep_fire & bus.button_l);
`else
    assign step_inc = r_edge & ~l_edge;
    assign step_dec = l_edge & ~r_edge;
`endif

    assign edit_en = editing && in_set && !mid_edge && (step_inc || step_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (in_set) state_d = S_E_YEAR;
            S_E_YEAR:  if (!in_set) state_d = S_IDLE; else if (mid_edge) state_d = S_E_MONTH;
            S_E_MONTH: if (!in_set) state_d = S_IDLE; else if (mid_edge) state_d = S_E_DAY;
            S_E_DAY:   if (!in_set) state_d = S_IDLE; else if (mid_edge) state_d = S_E_HOUR;
            S_E_HOUR:  if (!in_set) state_d = S_IDLE; else if (mid_edge) state_d = S_E_MIN;
            S_E_MIN:   if (!in_set) state_d = S_IDLE; else if (mid_edge) state_d = S_E_SEC;
            S_E_SEC:   if (!in_set) state_d = S_IDLE; else if (mid_edge) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_DONE;
            S_DONE:    if (!in_set) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        field_sel_c  = F_NONE;
        set_active_c = 1'b0;
        load_c       = 1'b0;
        unique case (state_q)
            S_E_YEAR:  begin field_sel_c = F_YEAR;  set_active_c = 1'b1; end
            S_E_MONTH: begin field_sel_c = F_MONTH; set_active_c = 1'b1; end
            S_E_DAY:   begin field_sel_c = F_DAY;   set_active_c = 1'b1; end
            S_E_HOUR:  begin field_sel_c = F_HOUR;  set_active_c = 1'b1; end
            S_E_MIN:   begin field_sel_c = F_MIN;   set_active_c = 1'b1; end
            S_E_SEC:   begin field_sel_c = F_SEC;   set_active_c = 1'b1; end
            S_COMMIT:  begin set_active_c = 1'b1;   load_c = 1'b1;       end
            default:   ;
        endcase
    end

    assign dim_cur = days_in_month(month_q, year_q);

    // One shared stepper serves the active field; in E_YEAR it is the low pair of the year.
    always_comb begin
        fld_val = BCD_ZERO;
        fld_lo  = BCD_ZERO;
        fld_hi  = PAIR_MAX;
        unique case (state_q)
            S_E_YEAR:  begin fld_val = year_q[7:0]; fld_lo = BCD_ZERO;  fld_hi = PAIR_MAX;   end
            S_E_MONTH: begin fld_val = month_q;     fld_lo = MONTH_MIN; fld_hi = MONTH_MAX;  end
            S_E_DAY:   begin fld_val = day_q;       fld_lo = DAY_MIN;   fld_hi = dim_cur;    end
            S_E_HOUR:  begin fld_val = hour_q;      fld_lo = BCD_ZERO;  fld_hi = HOUR_MAX;   end
            S_E_MIN:   begin fld_val = minute_q;    fld_lo = BCD_ZERO;  fld_hi = MINSEC_MAX; end
            S_E_SEC:   begin fld_val = sec_q;       fld_lo = BCD_ZERO;  fld_hi = MINSEC_MAX; end
            default:   ;
        endcase
    end

    bcd_step u_field (
        .value  (fld_val),
        .lo_lim (fld_lo),
        .hi_lim (fld_hi),
        .inc    (step_inc),
        .dec    (step_dec),
        .result (fld_res),
        .wrap   (fld_wrap)
    );

    bcd_step u_year_hi (
        .value  (year_q[15:8]),
        .lo_lim (BCD_ZERO),
        .hi_lim (PAIR_MAX),
        .inc    (step_inc & fld_wrap),
        .dec    (step_dec & fld_wrap),
        .result (yhi_res),
        .wrap   (yhi_wrap)
    );

    assign year_chain = {yhi_res, fld_res};
    assign year_ok    = bcd_ok(year_q[15:8]) && bcd_ok(year_q[7:0]);

    // The chained pair counts 0000..9999; the YEAR_MIN/YEAR_MAX window is enforced here.
    always_comb begin
        year_next = year_q;
        if (step_inc)
            year_next = (!year_ok || yhi_wrap || year_q < YEAR_MIN || year_q >= YEAR_MAX) ? YEAR_MIN : year_chain;
        else if (step_dec)
            year_next = (!year_ok || yhi_wrap || year_q > YEAR_MAX || year_q <= YEAR_MIN) ? YEAR_MAX : year_chain;
    end

    assign dim_new = days_in_month((state_q == S_E_MONTH) ? fld_res : month_q,
                                   (state_q == S_E_YEAR) ? year_next : year_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year_q   <= YEAR_RESET;
            month_q  <= MONTH_MIN;
            day_q    <= DAY_MIN;
            hour_q   <= BCD_ZERO;
            minute_q <= BCD_ZERO;
            sec_q    <= BCD_ZERO;
        end else if (state_q == S_IDLE && in_set) begin
            year_q   <= bus.cur_year;
            month_q  <= bus.cur_month;
            day_q    <= bus.cur_day;
            hour_q   <= bus.cur_hour;
            minute_q <= bus.cur_minute;
            sec_q    <= bus.cur_sec;
        end else if (edit_en) begin
            unique case (state_q)
                S_E_YEAR: begin
                    year_q <= year_next;
                    if (day_q > dim_new) day_q <= dim_new;
                end
                S_E_MONTH: begin
                    month_q <= fld_res;
                    if (day_q > dim_new) day_q <= dim_new;
                end
                S_E_DAY:  day_q    <= fld_res;
                S_E_HOUR: hour_q   <= fld_res;
                S_E_MIN:  minute_q <= fld_res;
                S_E_SEC:  sec_q    <= fld_res;
                default:  ;
            endcase
        end
    end

    assign bus.year       = year_q;
    assign bus.month      = month_q;
    assign bus.day        = day_q;
    assign bus.hour       = hour_q;
    assign bus.minute     = minute_q;
    assign bus.sec        = sec_q;
    assign bus.field_sel  = field_sel_c;
    assign bus.set_active = set_active_c;
    assign bus.load       = load_c;

endmodule

// File: tb/tb_time_set_fsm.sv
// tb/tb_time_set_fsm.sv - scoreboard bench for time_set_fsm (autorepeat case under TIME_SET_AUTOREPEAT_EN)
module tb_time_set_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   load_cnt = 0;

    always #5 clk = ~clk;

    time_set_if bus ();

    time_set_fsm #(
        .SET_MODE   (4'd0),
        .YEAR_RESET (16'h2023),
        .YEAR_MIN   (16'h2000),
        .YEAR_MAX   (16'h2099)
`ifdef TIME_SET_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY  (24'd10),
        .REPEAT_PERIOD (24'd4)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  sec;
        logic [2:0]  fsel;
        logic        act;
        logic        ld;
    } snap_t;

    typedef struct {
        string name;
        int    due;
        snap_t val;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    snap_t m;
    snap_t obs;
    snap_t rst_snap;

    assign obs = {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.sec,
                  bus.field_sel, bus.set_active, bus.load};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.load) load_cnt++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            total++;
            if (obs !== mon_e.val) begin
                bad++;
                $display("FAIL %s: got %h expected %h", mon_e.name, obs, mon_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_next(input string name);
        exp_t e;
        e.name = name;
        e.due  = cyc + 1;
        e.val  = m;
        sb_q.push_back(e);
    endtask

    task automatic press(input logic mid, input logic l, input logic r, input string name);
        tick();
        bus.button_mid = mid;
        bus.button_l   = l;
        bus.button_r   = r;
        expect_next(name);
        tick();
        bus.button_mid = 1'b0;
        bus.button_l   = 1'b0;
        bus.button_r   = 1'b0;
    endtask

    task automatic enter(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                         input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        tick();
        bus.cur_year   = y;
        bus.cur_month  = mo;
        bus.cur_day    = d;
        bus.cur_hour   = h;
        bus.cur_minute = mi;
        bus.cur_sec    = s;
        bus.mode       = 4'd0;
        m = '{year: y, month: mo, day: d, hour: h, minute: mi, sec: s, fsel: 3'd1, act: 1'b1, ld: 1'b0};
        expect_next("capture");
        tick();
    endtask

    task automatic leave();
        tick();
        bus.mode = 4'd5;
        m.fsel = 3'd0;
        m.act  = 1'b0;
        m.ld   = 1'b0;
        expect_next("leave");
        tick();
    endtask

    task automatic test_reset();
        bus.mode = 4'd5;
        bus.button_mid = 1'b0;
        bus.button_l   = 1'b0;
        bus.button_r   = 1'b0;
        bus.cur_year   = 16'h0000;
        bus.cur_month  = 8'h00;
        bus.cur_day    = 8'h00;
        bus.cur_hour   = 8'h00;
        bus.cur_minute = 8'h00;
        bus.cur_sec    = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== rst_snap) begin
            bad++;
            $display("FAIL reset_values: got %h expected %h", obs, rst_snap);
        end
        tick();
        rst_n = 1'b1;
        m = rst_snap;
    endtask

    task automatic test_capture_commit();
        int lc;
        enter(16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59);
        for (int i = 2; i <= 6; i++) begin
            m.fsel = 3'(i);
            press(1'b1, 1'b0, 1'b0, "mid_advance");
        end
        lc = load_cnt;
        m.fsel = 3'd0;
        m.ld   = 1'b1;
        press(1'b1, 1'b0, 1'b0, "commit");
        m.act = 1'b0;
        m.ld  = 1'b0;
        expect_next("done");
        tick();
        tick();
        total++;
        if (load_cnt !== lc + 1) begin
            bad++;
            $display("FAIL load_once: got %0d pulses expected 1", load_cnt - lc);
        end
        leave();
    endtask

    task automatic test_day_clamp();
        enter(16'h2024, 8'h01, 8'h31, 8'h12, 8'h00, 8'h00);
        m.fsel = 3'd2;
        press(1'b1, 1'b0, 1'b0, "to_month");
        m.month = 8'h02;
        m.day   = 8'h29;
        press(1'b0, 1'b0, 1'b1, "clamp_leap");
        leave();
        enter(16'h2023, 8'h01, 8'h31, 8'h12, 8'h00, 8'h00);
        m.fsel = 3'd2;
        press(1'b1, 1'b0, 1'b0, "to_month");
        m.month = 8'h02;
        m.day   = 8'h28;
        press(1'b0, 1'b0, 1'b1, "clamp_common");
        leave();
    endtask

    task automatic test_wraps();
        enter(16'h2099, 8'h12, 8'h01, 8'h00, 8'h59, 8'h00);
        m.year = 16'h2000;
        press(1'b0, 1'b0, 1'b1, "year_wrap_up");
        m.year = 16'h2099;
        press(1'b0, 1'b1, 1'b0, "year_wrap_down");
        m.fsel = 3'd2;
        press(1'b1, 1'b0, 1'b0, "to_month");
        m.month = 8'h01;
        press(1'b0, 1'b0, 1'b1, "month_wrap");
        m.fsel = 3'd3;
        press(1'b1, 1'b0, 1'b0, "to_day");
        m.fsel = 3'd4;
        press(1'b1, 1'b0, 1'b0, "to_hour");
        m.hour = 8'h23;
        press(1'b0, 1'b1, 1'b0, "hour_wrap");
        m.fsel = 3'd5;
        press(1'b1, 1'b0, 1'b0, "to_minute");
        m.minute = 8'h00;
        press(1'b0, 1'b0, 1'b1, "minute_wrap");
        leave();
    endtask

    task automatic test_abort();
        int lc;
        enter(16'h2024, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30);
        for (int i = 2; i <= 4; i++) begin
            m.fsel = 3'(i);
            press(1'b1, 1'b0, 1'b0, "abort_advance");
        end
        m.hour = 8'h11;
        press(1'b0, 1'b0, 1'b1, "hour_inc");
        lc = load_cnt;
        tick();
        bus.mode = 4'd2;
        m.fsel = 3'd0;
        m.act  = 1'b0;
        expect_next("abort");
        tick();
        tick();
        tick();
        total++;
        if (load_cnt !== lc) begin
            bad++;
            $display("FAIL abort_no_load: got %0d pulses expected 0", load_cnt - lc);
        end
    endtask

    task automatic test_simultaneous();
        enter(16'h2024, 8'h03, 8'h10, 8'h05, 8'h06, 8'h07);
        press(1'b0, 1'b1, 1'b1, "r_and_l");
        m.fsel = 3'd2;
        press(1'b1, 1'b0, 1'b1, "mid_and_r");
        m.fsel = 3'd3;
        press(1'b1, 1'b0, 1'b0, "to_day");
        m.day = 8'h11;
        press(1'b0, 1'b0, 1'b1, "day_inc");
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== rst_snap) begin
            bad++;
            $display("FAIL async_reset: got %h expected %h", obs, rst_snap);
        end
        tick();
        rst_n = 1'b1;
        bus.mode = 4'd5;
        tick();
    endtask

`ifdef TIME_SET_AUTOREPEAT_EN
    task automatic test_autorepeat();
        enter(16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        for (int i = 2; i <= 6; i++) begin
            m.fsel = 3'(i);
            press(1'b1, 1'b0, 1'b0, "rep_advance");
        end
        tick();
        bus.button_r = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        bus.button_r = 1'b0;
        tick();
        total++;
        if (bus.sec !== 8'h06) begin
            bad++;
            $display("FAIL autorepeat: got sec=%h expected 06", bus.sec);
        end
        leave();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_snap = '{year: 16'h2023, month: 8'h01, day: 8'h01, hour: 8'h00, minute: 8'h00,
                     sec: 8'h00, fsel: 3'd0, act: 1'b0, ld: 1'b0};
        test_reset();
        test_capture_commit();
        test_day_clamp();
        test_wraps();
        test_abort();
        test_simultaneous();
`ifdef TIME_SET_AUTOREPEAT_EN
        test_autorepeat();
`endif
        tick();
        tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
